// File: rtl/rom_download_sequencer.sv
// ROM download sequencer: captures data_io bytes into a FIFO and commits them
// to two SDRAM ports using req/ack toggles. Optional checksum via ROMDL_CHECKSUM_EN.
module rom_download_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  ROM_INDEX  = 8'h00,
  parameter logic [24:0] BG_BASE    = 25'h10000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        p1_req,
  input  logic        p1_ack,
  output logic [22:0] p1_a,
  output logic [1:0]  p1_ds,
  output logic [15:0] p1_d,
  output logic        p2_req,
  input  logic        p2_ack,
  output logic [14:0] p2_a,
  output logic [1:0]  p2_ds,
  output logic [15:0] p2_d,
  output logic        rom_init,
  output logic        busy,
  output logic        rom_loaded,
  output logic        overflow,
  output logic [15:0] rom_sum
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nx;

  logic          rom_cond, start, wr_q, seen;
  logic          push_req, push_ok, pop, full, done;
  logic          bg_q, p2_pend, in_bg;
  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [24:0]   head_addr, b;
  logic [7:0]    head_data;

  assign rom_cond  = ioctl_downl && (ioctl_index == ROM_INDEX);
  assign start     = rom_cond && !rom_init;
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign push_req  = rom_init && ioctl_wr && !wr_q;
  assign pop       = (state == IDLE) && (count != '0) && !start;
  assign push_ok   = push_req && (!full || pop);
  assign head_addr = mem[rptr][32:8];
  assign head_data = mem[rptr][7:0];
  assign b         = head_addr - BG_BASE;
  // b[24:16]==0 with addr>=BG_BASE is the 64 KiB window test without overflowing BG_BASE+64K
  assign in_bg     = (head_addr >= BG_BASE) && (b[24:16] == '0);
  assign done      = (p1_ack == p1_req) && (!p2_pend || (p2_ack == p2_req));
  assign busy      = (count != '0) || (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (count != '0) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (start) state_nx = IDLE;
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wptr] <= {ioctl_addr, ioctl_dout};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rom_init   <= 1'b0;
      wr_q       <= 1'b0;
      seen       <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      bg_q       <= 1'b0;
      p2_pend    <= 1'b0;
      p1_req     <= 1'b0;
      p2_req     <= 1'b0;
      p1_a       <= '0;
      p1_ds      <= '0;
      p1_d       <= '0;
      p2_a       <= '0;
      p2_ds      <= '0;
      p2_d       <= '0;
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state    <= state_nx;
      rom_init <= rom_cond;
      wr_q     <= ioctl_wr;
      if (start) begin
        seen       <= 1'b1;
        wptr       <= '0;
        rptr       <= '0;
        count      <= '0;
        p2_pend    <= 1'b0;
        p1_req     <= p1_ack;
        p2_req     <= p2_ack;
        rom_loaded <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        if (push_ok) wptr <= wptr + 1'b1;
        if (pop)     rptr <= rptr + 1'b1;
        count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
        if (push_req && !push_ok) overflow <= 1'b1;
        if (pop) begin
          p1_a  <= head_addr[23:1];
          p1_ds <= {head_addr[0], ~head_addr[0]};
          p1_d  <= {head_data, head_data};
          bg_q  <= in_bg;
          if (in_bg) begin
            p2_a  <= {b[13:0], b[15]};
            p2_ds <= {b[14], ~b[14]};
            p2_d  <= {head_data, head_data};
          end
        end
        if (state == ISSUE) begin
          p1_req  <= ~p1_req;
          p2_pend <= bg_q;
          if (bg_q) p2_req <= ~p2_req;
        end
        if (!rom_init && seen && (count == '0) && (state == IDLE))
          rom_loaded <= 1'b1;
      end
    end
  end

`ifdef ROMDL_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)     rom_sum <= '0;
    else if (start)   rom_sum <= '0;
    else if (push_ok) rom_sum <= rom_sum + {8'h00, ioctl_dout};
  end
`else
  assign rom_sum = '0;
`endif

endmodule

// File: tb/tb_rom_download_sequencer.sv
// Directed bench for rom_download_sequencer: write ordering, port-2 mapping,
// overflow, completion timing, reset recovery and checksum.
module tb_rom_download_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_downl = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        p1_req, p2_req, rom_init, busy, rom_loaded, overflow;
  logic        p1_ack = 1'b0, p2_ack = 1'b0;
  logic [22:0] p1_a;
  logic [14:0] p2_a;
  logic [1:0]  p1_ds, p2_ds;
  logic [15:0] p1_d, p2_d, rom_sum;

  int errors = 0;
  int checks = 0;

  rom_download_sequencer #(.FIFO_DEPTH(4), .ROM_INDEX(8'h00), .BG_BASE(25'h10000)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_downl(ioctl_downl),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .p1_req(p1_req), .p1_ack(p1_ack), .p1_a(p1_a),
    .p1_ds(p1_ds), .p1_d(p1_d), .p2_req(p2_req), .p2_ack(p2_ack), .p2_a(p2_a),
    .p2_ds(p2_ds), .p2_d(p2_d), .rom_init(rom_init), .busy(busy),
    .rom_loaded(rom_loaded), .overflow(overflow), .rom_sum(rom_sum)
  );

  always #12 clk_sys = ~clk_sys;

  // Ack responder: echoes each req toggle two negedges later while enabled
  logic ack_en = 1'b0;
  int   flip_req = 0, flip_done = 0, cnt1 = 0, cnt2 = 0;
  always @(negedge clk_sys) begin
    if (flip_req != flip_done) begin
      p1_ack = ~p1_ack;
      flip_done = flip_req;
    end else if (ack_en && p1_ack !== p1_req) begin
      cnt1++;
      if (cnt1 >= 2) begin p1_ack = p1_req; cnt1 = 0; end
    end else cnt1 = 0;
    if (ack_en && p2_ack !== p2_req) begin
      cnt2++;
      if (cnt2 >= 2) begin p2_ack = p2_req; cnt2 = 0; end
    end else cnt2 = 0;
  end

  // Write log: one entry per p1_req toggle while out of reset
  logic [22:0] l1a [256];
  logic [1:0]  l1ds[256];
  logic [15:0] l1d [256];
  logic        l2t [256];
  logic [14:0] l2a [256];
  logic [1:0]  l2ds[256];
  logic [15:0] l2d [256];
  int   log_n = 0;
  logic last1 = 1'b0, last2 = 1'b0;
  always @(negedge clk_sys) begin
    if (reset_n && p1_req !== last1 && log_n < 256) begin
      l1a[log_n] = p1_a; l1ds[log_n] = p1_ds; l1d[log_n] = p1_d;
      l2t[log_n] = (p2_req !== last2);
      l2a[log_n] = p2_a; l2ds[log_n] = p2_ds; l2d[log_n] = p2_d;
      log_n++;
    end
    last1 = p1_req;
    last2 = p2_req;
  end

  int base = 0;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_downl = 1'b0;
    tick(2);
    ioctl_index = idx;
    ioctl_downl = 1'b1;
    tick(3);
    base = log_n;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget && busy; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick(3);
    checks++;
    if ({p1_req, p2_req, rom_init, busy, rom_loaded, overflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000",
               {p1_req, p2_req, rom_init, busy, rom_loaded, overflow});
    end
    checks++;
    if ({p1_a, p1_ds, p1_d, p2_a, p2_ds, p2_d, rom_sum} !== '0) begin
      errors++;
      $display("FAIL reset_data: p1_a=%h p1_d=%h p2_a=%h p2_d=%h sum=%h required 0",
               p1_a, p1_d, p2_a, p2_d, rom_sum);
    end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_linear;
    start_dl(8'h00);
    ack_en = 1'b1;
    send_byte(25'h0, 8'h11);
    send_byte(25'h1, 8'h22);
    wait_idle(40);
    checks++;
    if (log_n - base !== 2) begin
      errors++; $display("FAIL lin_count: got %0d writes required 2", log_n - base);
    end
    checks++;
    if ({l1a[base], l1ds[base], l1d[base], l2t[base]} !== {23'h0, 2'b01, 16'h1111, 1'b0}) begin
      errors++;
      $display("FAIL lin_w0: a=%h ds=%b d=%h p2tog=%b required a=0 ds=01 d=1111 p2tog=0",
               l1a[base], l1ds[base], l1d[base], l2t[base]);
    end
    checks++;
    if ({l1a[base+1], l1ds[base+1], l1d[base+1], l2t[base+1]} !== {23'h0, 2'b10, 16'h2222, 1'b0}) begin
      errors++;
      $display("FAIL lin_w1: a=%h ds=%b d=%h p2tog=%b required a=0 ds=10 d=2222 p2tog=0",
               l1a[base+1], l1ds[base+1], l1d[base+1], l2t[base+1]);
    end
    ioctl_downl = 1'b0;
    tick(4);
    checks++;
    if (rom_loaded !== 1'b1) begin
      errors++; $display("FAIL lin_loaded: rom_loaded=%b required 1", rom_loaded);
    end
  endtask

  task automatic test_non_rom;
    int n0;
    start_dl(8'hFF);
    n0 = log_n;
    send_byte(25'h5, 8'h99);
    tick(4);
    checks++;
    if ({rom_init, busy, rom_loaded, log_n - n0 == 0} !== 4'b0011) begin
      errors++;
      $display("FAIL nonrom: rom_init=%b busy=%b rom_loaded=%b new_writes=%0d required 0,0,1,0",
               rom_init, busy, rom_loaded, log_n - n0);
    end
  endtask

  task automatic test_bg_region;
    logic [24:0] addr, bb;
    logic [14:0] exp_a;
    logic [1:0]  exp_ds;
    addr = 25'h1C001;
    bb = addr - 25'h10000;
    exp_a = {bb[13:0], bb[15]};
    exp_ds = {bb[14], ~bb[14]};
    start_dl(8'h00);
    send_byte(addr, 8'hA5);
    wait_idle(40);
    checks++;
    if ({l1a[base], l1ds[base], l1d[base]} !== {23'hE000, 2'b10, 16'hA5A5}) begin
      errors++;
      $display("FAIL bg_p1: a=%h ds=%b d=%h required a=E000 ds=10 d=A5A5",
               l1a[base], l1ds[base], l1d[base]);
    end
    checks++;
    if ({l2t[base], l2a[base], l2ds[base], l2d[base]} !== {1'b1, exp_a, exp_ds, 16'hA5A5}) begin
      errors++;
      $display("FAIL bg_p2: tog=%b a=%h ds=%b d=%h required tog=1 a=%h ds=%b d=A5A5",
               l2t[base], l2a[base], l2ds[base], l2d[base], exp_a, exp_ds);
    end
  endtask

  task automatic test_overflow;
    start_dl(8'h00);
    ack_en = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(25'h100 + 25'(i), 8'h30 + 8'(i));
    checks++;
    if ({overflow, busy} !== 2'b11) begin
      errors++; $display("FAIL ovf_flag: overflow=%b busy=%b required 1,1", overflow, busy);
    end
    ack_en = 1'b1;
    wait_idle(100);
    checks++;
    if (log_n - base !== 5) begin
      errors++; $display("FAIL ovf_count: got %0d writes required 5", log_n - base);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({l1a[base+i], l1d[base+i]} !== {23'h80 + 23'(i / 2), {2{8'h30 + 8'(i)}}}) begin
        errors++;
        $display("FAIL ovf_order[%0d]: a=%h d=%h required a=%h d=%h", i, l1a[base+i],
                 l1d[base+i], 23'h80 + 23'(i / 2), {2{8'h30 + 8'(i)}});
      end
    end
  endtask

  task automatic test_drain_completion;
    int i;
    start_dl(8'h00);
    checks++;
    if ({overflow, rom_loaded} !== 2'b00) begin
      errors++;
      $display("FAIL start_clear: overflow=%b rom_loaded=%b required 0,0", overflow, rom_loaded);
    end
    ack_en = 1'b0;
    send_byte(25'h300, 8'h01);
    send_byte(25'h301, 8'h02);
    send_byte(25'h302, 8'h03);
    ioctl_downl = 1'b0;
    tick(5);
    checks++;
    if ({rom_loaded, busy} !== 2'b01) begin
      errors++;
      $display("FAIL drain_early: rom_loaded=%b busy=%b required 0,1", rom_loaded, busy);
    end
    ack_en = 1'b1;
    for (i = 0; i < 60 && !rom_loaded; i++) tick();
    checks++;
    if ({rom_loaded, busy, log_n - base == 3} !== 3'b101) begin
      errors++;
      $display("FAIL drain_done: rom_loaded=%b busy=%b writes=%0d required 1,0,3",
               rom_loaded, busy, log_n - base);
    end
    checks++;
    if (l1d[base+2] !== 16'h0303) begin
      errors++; $display("FAIL drain_last: d=%h required 0303", l1d[base+2]);
    end
  endtask

  task automatic test_reset_mid_wait;
    start_dl(8'h00);
    ack_en = 1'b0;
    send_byte(25'h40, 8'h77);
    tick(2);
    reset_n = 1'b0;
    ioctl_downl = 1'b0;
    tick(2);
    checks++;
    if ({p1_req, p2_req, busy, rom_init} !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid: p1_req=%b p2_req=%b busy=%b rom_init=%b required 0000",
               p1_req, p2_req, busy, rom_init);
    end
    if (p1_ack === 1'b0) flip_req++;
    tick(2);
    reset_n = 1'b1;
    tick();
    start_dl(8'h00);
    checks++;
    if ({p1_req, p1_ack} !== 2'b11) begin
      errors++;
      $display("FAIL rst_resync: p1_req=%b p1_ack=%b required 1,1", p1_req, p1_ack);
    end
    ack_en = 1'b1;
    send_byte(25'h41, 8'h5A);
    wait_idle(40);
    checks++;
    if ({log_n - base == 1, l1a[base], l1ds[base], l1d[base]} !== {1'b1, 23'h20, 2'b10, 16'h5A5A}) begin
      errors++;
      $display("FAIL rst_first: writes=%0d a=%h ds=%b d=%h required 1 a=20 ds=10 d=5A5A",
               log_n - base, l1a[base], l1ds[base], l1d[base]);
    end
  endtask

  task automatic test_checksum;
    logic [15:0] exp;
`ifdef ROMDL_CHECKSUM_EN
    exp = 16'h0200;
`else
    exp = 16'h0000;
`endif
    start_dl(8'h00);
    send_byte(25'h500, 8'hFF);
    send_byte(25'h501, 8'hFF);
    send_byte(25'h502, 8'h02);
    wait_idle(60);
    checks++;
    if (rom_sum !== exp) begin
      errors++; $display("FAIL checksum: rom_sum=%h required %h", rom_sum, exp);
    end
  endtask

  initial begin
    test_reset;
    test_linear;
    test_non_rom;
    test_bg_region;
    test_overflow;
    test_drain_completion;
    test_reset_mid_wait;
    test_checksum;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
